// File: rtl/bus_rr_arbiter_pkg.sv
// Shared bus definitions: owner encoding, tenure width, default hold limit.
// Pure declarations; no logic, no latency, no flow control.
package bus_rr_arbiter_pkg;

   localparam int BUS_OWNER_W          = 2;
   localparam int BUS_MASTERS          = 4;
   localparam int BUS_TENURE_W         = 5;
   localparam int BUS_MAX_HOLD_DEFAULT = 16;

   typedef enum logic [BUS_OWNER_W-1:0] {
      BUS_OWNER_MASTER_0 = 2'd0,
      BUS_OWNER_MASTER_1 = 2'd1,
      BUS_OWNER_MASTER_2 = 2'd2,
      BUS_OWNER_MASTER_3 = 2'd3
   } bus_owner_e;

   // Active-low one-cold grant vector for an encoded owner.
   function automatic logic [BUS_MASTERS-1:0] owner_grnt_n(input logic [BUS_OWNER_W-1:0] o);
      return ~(4'b0001 << o);
   endfunction

endpackage

// File: rtl/bus_rr_pick.sv
// Round-robin search from owner+1 upward, owner itself last unless excluded.
// Purely combinational, zero latency; no backpressure.
module bus_rr_pick
   import bus_rr_arbiter_pkg::*;
(
   input  logic [BUS_OWNER_W-1:0] owner,
   input  logic [BUS_MASTERS-1:0] req_,
   input  logic                   exclude_owner,
   output logic [BUS_OWNER_W-1:0] next_owner,
   output logic                   found
);

   logic [BUS_OWNER_W-1:0] cand;

   always_comb begin
      next_owner = owner;
      found      = 1'b0;
      cand       = owner;
      if (!exclude_owner && !req_[owner]) begin
         found = 1'b1;
      end
      // Walk farthest-first so the nearest requester after owner wins.
      for (int i = 3; i >= 1; i--) begin
         cand = owner + BUS_OWNER_W'(i);
         if (!req_[cand]) begin
            next_owner = cand;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Four-master round-robin bus arbiter with bounded tenure; grant one cycle after request.
// No backpressure: a contended owner is pre-empted after MAX_HOLD cycles.
module bus_rr_arbiter
   import bus_rr_arbiter_pkg::*;
#(
   parameter int MAX_HOLD = BUS_MAX_HOLD_DEFAULT
)(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   m0_req_,
   input  logic                   m1_req_,
   input  logic                   m2_req_,
   input  logic                   m3_req_,
   output logic                   m0_grnt_,
   output logic                   m1_grnt_,
   output logic                   m2_grnt_,
   output logic                   m3_grnt_,
   output logic [BUS_OWNER_W-1:0] owner
);

   localparam logic [BUS_TENURE_W-1:0] TENURE_MAX = BUS_TENURE_W'(MAX_HOLD - 1);

   logic [BUS_MASTERS-1:0]  req_;
   logic [BUS_TENURE_W-1:0] tenure;
   logic [BUS_TENURE_W-1:0] tenure_nxt;
   logic [BUS_OWNER_W-1:0]  owner_nxt;
   logic [BUS_OWNER_W-1:0]  pick_owner;
   logic                    pick_found;
   logic                    owner_req;
   logic                    other_req;

   assign req_      = {m3_req_, m2_req_, m1_req_, m0_req_};
   assign owner_req = ~req_[owner];
   assign other_req = |(~req_ & ~(4'b0001 << owner));

   // A requesting owner only ever hands over to someone else, so exclude it.
   bus_rr_pick u_pick (
      .owner         (owner),
      .req_          (req_),
      .exclude_owner (owner_req),
      .next_owner    (pick_owner),
      .found         (pick_found)
   );

   always_comb begin
      owner_nxt  = owner;
      tenure_nxt = tenure;
      if (owner_req) begin
         if (other_req && tenure == TENURE_MAX) begin
            owner_nxt = pick_owner;
         end
      end else if (pick_found) begin
         owner_nxt = pick_owner;
      end

      if (owner_nxt != owner) begin
         tenure_nxt = '0;
      end else if (owner_req && tenure < TENURE_MAX) begin
         tenure_nxt = tenure + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         owner  <= BUS_OWNER_MASTER_0;
         tenure <= '0;
      end else begin
         owner  <= owner_nxt;
         tenure <= tenure_nxt;
      end
   end

   // Grants come straight off the owner flops so they always agree with owner.
   assign {m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_} = owner_grnt_n(owner);

endmodule
